// File: rtl/layer_seq_pkg.sv
// rtl/layer_seq_pkg.sv - opcodes, FSM states and error codes shared by the layer sequencer
package layer_seq_pkg;

   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_CONV  = 3'b001;
   localparam logic [2:0] OP_DENSE = 3'b010;
   localparam logic [2:0] OP_POOL  = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_START,
      S_WAIT,
      S_ADV,
      S_FIN,
      S_ERR
   } seq_state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_BAD_OP  = 2'b01,
      ERR_ABORT   = 2'b10,
      ERR_TIMEOUT = 2'b11
   } err_code_t;

   function automatic logic op_valid(input logic [2:0] op);
      return (op == OP_CONV) || (op == OP_DENSE) || (op == OP_POOL);
   endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// rtl/layer_sequencer_if.sv - comp_sel / start_comp / comp_done handshake to the computation controller
interface layer_sequencer_if;

   logic [2:0] comp_sel;
   logic       start_comp;
   logic       comp_done;

   modport master (output comp_sel, output start_comp, input comp_done);
   modport slave  (input comp_sel, input start_comp, output comp_done);

endinterface

// File: rtl/layer_seq_tbl.sv
// rtl/layer_seq_tbl.sv - layer opcode table, one write port and one asynchronous read port
module layer_seq_tbl #(
   parameter int MAX_LAYERS = 16,
   parameter int IDX_W      = $clog2(MAX_LAYERS)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [2:0]       wr_op,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [2:0]       rd_op
);

   // contents are deliberately not reset; the host loads the table before go
   logic [2:0] mem [MAX_LAYERS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_op;
      end
   end

   assign rd_op = mem[rd_addr];

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - steps an opcode table through the computation controller; LAYER_SEQ_TIMEOUT_EN adds a WAIT watchdog
module layer_sequencer
   import layer_seq_pkg::*;
#(
   parameter int MAX_LAYERS = 16,
   parameter int IDX_W      = $clog2(MAX_LAYERS),
   parameter int TO_W       = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tbl_wr_en,
   input  logic [IDX_W-1:0]   tbl_wr_addr,
   input  logic [2:0]         tbl_wr_op,
   input  logic [IDX_W:0]     num_layers,
   input  logic               go,
   input  logic               abort,
   layer_sequencer_if.master  comp,
   output logic               busy,
   output logic               seq_done,
   output logic               err,
   output logic [1:0]         err_code,
   output logic [IDX_W-1:0]   cur_layer
);

   localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_LAYERS);

   seq_state_t     state;
   logic [IDX_W:0] n_q;
   logic [IDX_W:0] last_idx;
   logic [2:0]     sel_q;
   logic           start_q;
   logic           done_mask;
   logic [2:0]     tbl_rd_op;

   layer_seq_tbl #(
      .MAX_LAYERS (MAX_LAYERS),
      .IDX_W      (IDX_W)
   ) u_tbl (
      .clk     (clk),
      .wr_en   (tbl_wr_en),
      .wr_addr (tbl_wr_addr),
      .wr_op   (tbl_wr_op),
      .rd_addr (cur_layer),
      .rd_op   (tbl_rd_op)
   );

   assign last_idx        = n_q - 1'b1;
   assign comp.comp_sel   = sel_q;
   assign comp.start_comp = start_q;

`ifdef LAYER_SEQ_TIMEOUT_EN
   // trip on the cycle the counter would reach all-ones
   localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
   logic [TO_W-1:0] to_cnt;
`else
   logic unused_to_w;
   assign unused_to_w = ^TO_W;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         n_q       <= '0;
         cur_layer <= '0;
         sel_q     <= OP_NONE;
         start_q   <= 1'b0;
         busy      <= 1'b0;
         seq_done  <= 1'b0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
         done_mask <= 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         start_q  <= 1'b0;
         seq_done <= 1'b0;
         if (busy && abort) begin
            state    <= S_ERR;
            sel_q    <= OP_NONE;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_ABORT;
         end else begin
            case (state)
               S_IDLE: begin
                  if (go) begin
                     if (num_layers == '0) begin
                        seq_done <= 1'b1;
                     end else if (num_layers > MAX_CNT) begin
                        state    <= S_ERR;
                        err      <= 1'b1;
                        err_code <= ERR_BAD_OP;
                     end else begin
                        state     <= S_FETCH;
                        n_q       <= num_layers;
                        cur_layer <= '0;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        err_code  <= ERR_NONE;
                     end
                  end
               end
               // the opcode is captured here, so later table writes cannot disturb this layer
               S_FETCH: begin
                  if (op_valid(tbl_rd_op)) begin
                     state   <= S_START;
                     sel_q   <= tbl_rd_op;
                     start_q <= 1'b1;
                  end else begin
                     state    <= S_ERR;
                     busy     <= 1'b0;
                     err      <= 1'b1;
                     err_code <= ERR_BAD_OP;
                  end
               end
               S_START: begin
                  state     <= S_WAIT;
                  done_mask <= 1'b1;
`ifdef LAYER_SEQ_TIMEOUT_EN
                  to_cnt    <= '0;
`endif
               end
               // done_mask hides a done left over from the previous layer
               S_WAIT: begin
                  done_mask <= 1'b0;
                  if (!done_mask && comp.comp_done) begin
                     state <= S_ADV;
                     sel_q <= OP_NONE;
                  end
`ifdef LAYER_SEQ_TIMEOUT_EN
                  else if (to_cnt == TO_LAST) begin
                     state    <= S_ERR;
                     sel_q    <= OP_NONE;
                     busy     <= 1'b0;
                     err      <= 1'b1;
                     err_code <= ERR_TIMEOUT;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
`endif
               end
               S_ADV: begin
                  if ({1'b0, cur_layer} == last_idx) begin
                     state    <= S_FIN;
                     seq_done <= 1'b1;
                  end else begin
                     state     <= S_FETCH;
                     cur_layer <= cur_layer + 1'b1;
                  end
               end
               S_FIN: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               S_ERR: begin
                  state <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - randomized self-checking bench for layer_sequencer (timeout case follows LAYER_SEQ_TIMEOUT_EN)
module tb_layer_sequencer;

   localparam int MAXL   = 16;
   localparam int TOW    = 4;
   localparam int TO_CYC = (1 << TOW) - 1;
   localparam int W      = 180;
`ifdef LAYER_SEQ_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       tbl_wr_en;
   logic [3:0] tbl_wr_addr;
   logic [2:0] tbl_wr_op;
   logic [4:0] num_layers;
   logic       go;
   logic       abort;
   logic       busy;
   logic       seq_done;
   logic       err;
   logic [1:0] err_code;
   logic [3:0] cur_layer;

   layer_sequencer_if ifc ();

   layer_sequencer #(
      .MAX_LAYERS (MAXL),
      .TO_W       (TOW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tbl_wr_en   (tbl_wr_en),
      .tbl_wr_addr (tbl_wr_addr),
      .tbl_wr_op   (tbl_wr_op),
      .num_layers  (num_layers),
      .go          (go),
      .abort       (abort),
      .comp        (ifc),
      .busy        (busy),
      .seq_done    (seq_done),
      .err         (err),
      .err_code    (err_code),
      .cur_layer   (cur_layer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cur_t    = -1;
   int run_id   = 0;

   // reference model state: table image, per-layer done delays, sticky outputs
   logic [2:0] tbl_m [MAXL];
   int         dly   [MAXL];
   logic       m_err;
   logic [1:0] m_code;
   int         m_cur;

   // expected per-cycle view of one run, cycle 0 being the go cycle
   bit         e_busy  [W];
   bit         e_start [W];
   bit         e_sdone [W];
   bit         e_err   [W];
   bit         d_done  [W];
   logic [2:0] e_sel   [W];
   logic [1:0] e_code  [W];
   int         e_cur   [W];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s run=%0d t=%0d got=%0h exp=%0h", tag, run_id, cur_t, got, exp);
      end
   endtask

   function automatic bit op_ok(input logic [2:0] op);
      return (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
   endfunction

   task automatic build(input int n, input bit hold, input int ta, input int tr);
      int  f;
      int  s;
      int  a;
      int  dd;
      int  err_at;
      int  code_at;
      bit  done_all;
      for (int t = 0; t < W; t++) begin
         e_busy[t] = 0; e_start[t] = 0; e_sdone[t] = 0; e_sel[t] = 3'd0;
         e_err[t] = m_err; e_code[t] = m_code; e_cur[t] = m_cur; d_done[t] = hold;
      end
      err_at  = -1;
      code_at = 0;
      if (n == 0) begin
         e_sdone[1] = 1;
      end else if (n > MAXL) begin
         err_at  = 1;
         code_at = 1;
      end else begin
         for (int t = 1; t < W; t++) begin
            e_err[t] = 0; e_code[t] = 2'd0;
         end
         f = 1;
         done_all = 1;
         for (int k = 0; k < n; k++) begin
            for (int t = f; t < W; t++) e_cur[t] = k;
            e_busy[f] = 1;
            if (!op_ok(tbl_m[k])) begin
               err_at = f + 1; code_at = 1; done_all = 0;
               break;
            end
            s  = f + 1;
            dd = hold ? 2 : dly[k];
            e_start[s] = 1;
            if (TO_ON && (dd < 0 || dd > TO_CYC)) begin
               for (int t = s; t <= s + TO_CYC && t < W; t++) begin
                  e_busy[t] = 1; e_sel[t] = tbl_m[k];
               end
               err_at = s + TO_CYC + 1; code_at = 3; done_all = 0;
               break;
            end
            if (dd < 0) begin
               for (int t = s; t < W; t++) begin
                  e_busy[t] = 1; e_sel[t] = tbl_m[k];
               end
               done_all = 0;
               break;
            end
            a = s + dd;
            for (int t = s; t <= a && t < W; t++) begin
               e_busy[t] = 1; e_sel[t] = tbl_m[k];
            end
            if (a < W) d_done[a] = 1;
            if (a + 1 < W) e_busy[a + 1] = 1;
            f = a + 2;
         end
         if (done_all && f < W) begin
            e_busy[f] = 1; e_sdone[f] = 1;
         end
      end
      if (err_at >= 0) begin
         for (int t = err_at; t < W; t++) begin
            e_err[t] = 1; e_code[t] = 2'(code_at);
         end
      end
      if (ta >= 1 && ta < W - 1 && e_busy[ta]) begin
         for (int t = ta + 1; t < W; t++) begin
            e_busy[t] = 0; e_start[t] = 0; e_sel[t] = 3'd0; e_sdone[t] = 0;
            e_err[t] = 1; e_code[t] = 2'd2; e_cur[t] = e_cur[ta];
         end
      end
      if (tr >= 0) begin
         for (int t = tr + 1; t < W; t++) begin
            e_busy[t] = 0; e_start[t] = 0; e_sel[t] = 3'd0; e_sdone[t] = 0;
            e_err[t] = 0; e_code[t] = 2'd0; e_cur[t] = 0;
         end
      end
   endtask

   task automatic run(input int n, input bit hold, input int ta, input int tr,
                      input int wr_t, input logic [2:0] wr_op);
      run_id++;
      build(n, hold, ta, tr);
      for (int t = 0; t < W; t++) begin
         @(negedge clk);
         cur_t = t;
         check("busy", busy, e_busy[t]);
         check("start_comp", ifc.start_comp, e_start[t]);
         check("comp_sel", ifc.comp_sel, e_sel[t]);
         check("seq_done", seq_done, e_sdone[t]);
         check("err", err, e_err[t]);
         check("err_code", err_code, e_code[t]);
         check("cur_layer", cur_layer, e_cur[t]);
         go            = (t == 0);
         num_layers    = n[4:0];
         abort         = (t == ta);
         rst           = (t == tr);
         ifc.comp_done = d_done[t];
         tbl_wr_en     = (t == wr_t);
         tbl_wr_addr   = 4'd0;
         tbl_wr_op     = wr_op;
      end
      if (wr_t >= 0 && wr_t < W) tbl_m[0] = wr_op;
      m_err  = e_err[W-1];
      m_code = e_code[W-1];
      m_cur  = e_cur[W-1];
      @(negedge clk);
      go = 0; abort = 0; rst = 0; ifc.comp_done = 0; tbl_wr_en = 0;
   endtask

   task automatic wr(input int a, input logic [2:0] op);
      @(negedge clk);
      tbl_wr_en   = 1;
      tbl_wr_addr = a[3:0];
      tbl_wr_op   = op;
      @(negedge clk);
      tbl_wr_en   = 0;
      tbl_m[a]    = op;
   endtask

   initial begin
      rst = 1; go = 0; abort = 0; num_layers = '0;
      tbl_wr_en = 0; tbl_wr_addr = '0; tbl_wr_op = '0;
      ifc.comp_done = 0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_start", ifc.start_comp, 0);
      check("rst_sel", ifc.comp_sel, 0);
      check("rst_seq_done", seq_done, 0);
      check("rst_err", err, 0);
      check("rst_err_code", err_code, 0);
      check("rst_cur_layer", cur_layer, 0);
      rst = 0;
      m_err = 0; m_code = 2'd0; m_cur = 0;
      for (int k = 0; k < MAXL; k++) begin
         wr(k, 3'd1);
         dly[k] = 5;
      end

      // basic three-layer run
      wr(0, 3'd1); wr(1, 3'd2); wr(2, 3'd3);
      run(3, 0, -1, -1, -1, 3'd0);

      // done held high from before go
      ifc.comp_done = 1;
      repeat (2) @(negedge clk);
      run(3, 1, -1, -1, -1, 3'd0);

      // bad opcode in layer 1
      wr(1, 3'd7);
      run(3, 0, -1, -1, -1, 3'd0);
      wr(1, 3'd2);

      // abort in the second WAIT cycle of layer 0, then a clean rerun
      run(3, 0, 4, -1, -1, 3'd0);
      run(1, 0, -1, -1, 1, 3'd7);
      run(1, 0, -1, -1, -1, 3'd0);
      wr(0, 3'd1);

      // zero and oversize layer counts
      run(0, 0, -1, -1, -1, 3'd0);
      run(17, 0, -1, -1, -1, 3'd0);

      // controller never answers; reset lands mid-WAIT or after the timeout
      dly[0] = -1;
      run(1, 0, -1, 20, -1, 3'd0);

      for (int r = 0; r < 16; r++) begin
         int         n;
         int         ta;
         int         wt;
         int         pick;
         bit         hold;
         logic [2:0] op;
         for (int k = 0; k < MAXL; k++) begin
            if ($urandom_range(9) == 0) op = 3'($urandom_range(7));
            else                        op = 3'($urandom_range(3, 1));
            wr(k, op);
            dly[k] = int'($urandom_range(7, 2));
         end
         pick = int'($urandom_range(9));
         if (pick == 0)      n = 0;
         else if (pick == 1) n = int'($urandom_range(31, 17));
         else                n = int'($urandom_range(16, 1));
         hold = ($urandom_range(7) == 0);
         if ($urandom_range(2) == 0) ta = int'($urandom_range(80, 1));
         else                        ta = -1;
         if ($urandom_range(2) == 0) wt = 1;
         else                        wt = -1;
         op = 3'($urandom_range(7));
         if (hold) begin
            ifc.comp_done = 1;
            @(negedge clk);
         end
         run(n, hold, ta, -1, wt, op);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
